ddfs_freq_meter: RTL and testbench

Measures the output frequency of a DDFS sine stream and reports it as an estimated 23-bit frequency-control word in the same units as the synthesizer's `fcontrol` input. It counts hysteresis-qualified rising zero crossings of the signed 8-bit sample stream over a fixed gate window of 2^GATE_LOG2 clocks, then scales the count. It sits on the DDFS output, on the same clock, as a loop-back and self-check monitor.

---
 rtl/ddfs_freq_meter.sv | 120 ++++++++++++
 tb/tb_ddfs_freq_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_freq_meter.sv
// Frequency meter for a DDFS sine stream: counts hysteresis-qualified rising
// zero crossings over a 2^GATE_LOG2-clock gate and reports the count scaled to fcontrol units.
module ddfs_freq_meter #(
  parameter int GATE_LOG2 = 16,
  parameter int HYST      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  samp,
  output logic [22:0] fest,
  output logic        fest_valid,
  output logic        ovf
);

  localparam int CW = GATE_LOG2 + 1;
  localparam int SHIFT = 24 - GATE_LOG2;
  localparam logic signed [7:0] HYST_POS = 8'(HYST);
  localparam logic signed [7:0] HYST_NEG = -HYST_POS;

  typedef enum logic {
    WAIT_NEG = 1'b0,
    ARMED    = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic signed [7:0]    samp_s;
  logic                 is_neg;
  logic                 is_pos;
  logic                 xing;
  logic [GATE_LOG2-1:0] gate_q;
  logic                 win_last;
  logic [CW-1:0]        xcnt_q;
  logic [CW-1:0]        xcnt_sum;
  logic [CW-1:0]        win_total_q;
  logic                 win_done_q;
  logic [24:0]          scaled;

  assign samp_s = samp;
  assign is_neg = (samp_s <= HYST_NEG);
  assign is_pos = (samp_s >= HYST_POS);

  // Crossing detector: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_NEG;
    end else if (!en) begin
      state_q <= WAIT_NEG;
    end else begin
      state_q <= state_d;
    end
  end

  // Crossing detector: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_NEG: if (is_neg) state_d = ARMED;
      ARMED:    if (is_pos) state_d = WAIT_NEG;
      default:  state_d = WAIT_NEG;
    endcase
  end

  // Crossing detector: the ARMED -> WAIT_NEG transition is the event
  always_comb begin
    xing = 1'b0;
    if (en && state_q == ARMED && is_pos) xing = 1'b1;
  end

  assign win_last = en && (gate_q == '1);
  assign xcnt_sum = (xing && xcnt_q != '1) ? xcnt_q + 1'b1 : xcnt_q;

  // Gate and crossing counters; the last cycle's event is folded into the latched total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_q      <= '0;
      xcnt_q      <= '0;
      win_total_q <= '0;
      win_done_q  <= 1'b0;
    end else if (!en) begin
      gate_q     <= '0;
      xcnt_q     <= '0;
      win_done_q <= 1'b0;
    end else begin
      gate_q <= gate_q + 1'b1;
      if (win_last) begin
        xcnt_q      <= '0;
        win_total_q <= xcnt_sum;
        win_done_q  <= 1'b1;
      end else begin
        xcnt_q     <= xcnt_sum;
        win_done_q <= 1'b0;
      end
    end
  end

  assign scaled = 25'(win_total_q) << SHIFT;

  // Result register: one cycle after the window's last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fest       <= '0;
      ovf        <= 1'b0;
      fest_valid <= 1'b0;
    end else if (win_done_q && en) begin
      fest_valid <= 1'b1;
      if (scaled >= 25'h0800000) begin
        fest <= 23'h7FFFFF;
        ovf  <= 1'b1;
      end else begin
        fest <= scaled[22:0];
        ovf  <= 1'b0;
      end
    end else begin
      fest_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddfs_freq_meter.sv
// Bench for ddfs_freq_meter at GATE_LOG2=12, HYST=8: table of waveform vectors
// plus hand sequences for enable gating and mid-window reset.
module tb_ddfs_freq_meter;

  localparam int G = 12;
  localparam int WIN = 1 << G;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  samp;
  logic [22:0] fest;
  logic        fest_valid;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mode = 0;
  int phase = 0;

  logic [22:0] exp_lo_q[$];
  logic [22:0] exp_hi_q[$];
  logic        exp_ovf_q[$];
  int          exp_cyc_q[$];

  typedef struct {
    int          mode;
    int          nwin;
    logic [22:0] lo;
    logic [22:0] hi;
    logic        ovf;
  } vec_t;

  vec_t vecs[5];

  ddfs_freq_meter #(.GATE_LOG2(G), .HYST(8)) dut (
    .clk(clk), .rst(rst), .en(en), .samp(samp),
    .fest(fest), .fest_valid(fest_valid), .ovf(ovf)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Waveforms: 0 const, 1 square period 10, 2 +-5 toggle, 3 +-100 toggle, 4 triangle period 64
  function automatic logic [7:0] gen(input int m, input int p);
    int v;
    int k;
    v = 0;
    case (m)
      1: v = ((p % 10) < 5) ? 100 : -100;
      2: v = (p % 2 == 0) ? 5 : -5;
      3: v = (p % 2 == 0) ? -100 : 100;
      4: begin
        k = p % 64;
        v = (k < 32) ? (-124 + 8 * k) : (124 - 8 * (k - 32));
      end
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  task automatic check(input string name, input logic ok, input longint act, input longint exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: caller sits at a negedge; each step presents one sample for the next posedge.
  task automatic drive_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      samp = gen(mode, phase);
      phase++;
      @(negedge clk);
    end
  endtask

  task automatic push_windows(input int start, input int nwin, input logic [22:0] lo,
                              input logic [22:0] hi, input logic o);
    for (int w = 0; w < nwin; w++) begin
      exp_lo_q.push_back(lo);
      exp_hi_q.push_back(hi);
      exp_ovf_q.push_back(o);
      exp_cyc_q.push_back(start + WIN * (w + 1));
    end
  endtask

  task automatic check_drained(input string name);
    check(name, exp_lo_q.size() == 0, exp_lo_q.size(), 0);
    exp_lo_q.delete();
    exp_hi_q.delete();
    exp_ovf_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    en = 1'b0;
    drive_cycles(3);
    mode = v.mode;
    phase = 0;
    en = 1'b1;
    start = cyc + 1;
    push_windows(start, v.nwin, v.lo, v.hi, v.ovf);
    drive_cycles(v.nwin * WIN + 2);
    en = 1'b0;
    check_drained("missing_strobe");
  endtask

  // Scoreboard: pop and compare on every strobe
  always @(negedge clk) begin
    logic [22:0] lo;
    logic [22:0] hi;
    logic        o;
    int          c;
    if (!rst && fest_valid) begin
      if (exp_lo_q.size() == 0) begin
        check("unexpected_strobe", 1'b0, cyc, -1);
      end else begin
        lo = exp_lo_q.pop_front();
        hi = exp_hi_q.pop_front();
        o  = exp_ovf_q.pop_front();
        c  = exp_cyc_q.pop_front();
        n_cmp++;
        if (fest < lo || fest > hi) begin
          n_bad++;
          $display("FAIL fest: got %0d expected in [%0d,%0d]", fest, lo, hi);
        end
        check("ovf", ovf == o, ovf, o);
        check("strobe_cycle", cyc == c, cyc, c);
      end
    end
  end

  initial begin
    int   start;
    logic held;

    vecs[0] = '{mode: 2, nwin: 1, lo: 23'd0,       hi: 23'd0,       ovf: 1'b0};
    vecs[1] = '{mode: 0, nwin: 1, lo: 23'd0,       hi: 23'd0,       ovf: 1'b0};
    vecs[2] = '{mode: 1, nwin: 2, lo: 23'd1675264, hi: 23'd1679360, ovf: 1'b0};
    vecs[3] = '{mode: 4, nwin: 2, lo: 23'd258048,  hi: 23'd266240,  ovf: 1'b0};
    vecs[4] = '{mode: 3, nwin: 2, lo: 23'h7FFFFF,  hi: 23'h7FFFFF,  ovf: 1'b1};

    rst = 1'b1;
    en = 1'b0;
    samp = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_fest", fest == 23'd0, fest, 0);
    check("rst_ovf", ovf == 1'b0, ovf, 0);
    check("rst_valid", fest_valid == 1'b0, fest_valid, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Enable gating: half window, 100 cycles off, then a fresh full window
    mode = 4;
    phase = 0;
    en = 1'b1;
    drive_cycles(WIN / 2);
    en = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_cycles(1);
      if (fest != 23'h7FFFFF || ovf != 1'b1) held = 1'b0;
    end
    check("hold_while_disabled", held, {fest, ovf}, {23'h7FFFFF, 1'b1});
    phase = 0;
    en = 1'b1;
    start = cyc + 1;
    push_windows(start, 1, 23'd262144, 23'd262144, 1'b0);
    drive_cycles(WIN + 2);
    en = 1'b0;
    check_drained("missing_strobe_regate");

    // Asynchronous reset mid-window with a nonzero estimate held
    drive_cycles(3);
    mode = 4;
    phase = 0;
    en = 1'b1;
    drive_cycles(1000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_fest", fest == 23'd0, fest, 0);
    check("async_rst_ovf", ovf == 1'b0, ovf, 0);
    check("async_rst_valid", fest_valid == 1'b0, fest_valid, 0);
    drive_cycles(2);
    rst = 1'b0;
    phase = 0;
    start = cyc + 1;
    push_windows(start, 1, 23'd258048, 23'd266240, 1'b0);
    drive_cycles(WIN + 2);
    en = 1'b0;
    check_drained("missing_strobe_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
